// File: rtl/char_row_sequencer_if.sv
// Character stream from the row sequencer to the glyph renderer:
// one char code per transfer, tagged with its column and an end-of-row flag.
interface char_row_sequencer_if #(
  parameter int DATA_W = 7,
  parameter int COL_W  = 7
) ();
  logic              char_valid;
  logic              char_ready;
  logic [DATA_W-1:0] char_data;
  logic [COL_W-1:0]  char_col;
  logic              char_last;

  modport master (output char_valid, char_data, char_col, char_last, input char_ready);
  modport slave  (input char_valid, char_data, char_col, char_last, output char_ready);
endinterface

// File: rtl/char_row_sequencer.sv
// Reads one text row from the character ROM and streams it out in column order.
// Issue is credit-limited so ROM reads in flight plus FIFO entries never exceed the FIFO depth.
module char_row_sequencer #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 7,
  parameter int NUM_CHARS  = 80,
  parameter int ROM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic [ADDR_W-1:0]    rom_addr_o,
  input  logic [DATA_W-1:0]    rom_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  char_row_sequencer_if.master char_o
);

  localparam int COL_W = 7;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IF_W  = $clog2(ROM_LAT + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CHARS - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(NUM_CHARS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  function automatic logic [IF_W-1:0] count_tags(input logic [ROM_LAT-1:0] tags);
    logic [IF_W-1:0] n;
    n = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      n = n + IF_W'(tags[i]);
    end
    return n;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ROM_LAT-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                issue_s;
  logic                flush_s;
  logic                col_rst_s;
  logic                pop_s;
  logic                push_s;
  logic                credit_s;
  logic [IF_W-1:0]     in_flight_s;
  logic [CNT_W-1:0]    remain_s;

  // Counts are taken before this edge's pop, so a full FIFO being drained still blocks one issue.
  assign in_flight_s = count_tags(tag_q);
  assign credit_s    = (SUM_W'(in_flight_s) + SUM_W'(cnt_q)) < SUM_W'(FIFO_DEPTH);
  assign pop_s       = valid_q & char_o.char_ready;
  assign push_s      = tag_q[ROM_LAT-1];

  // Row FSM: start/abort handling, address issue and end-of-row detection.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rom_addr_d  = rom_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue_s     = 1'b0;
    flush_s     = 1'b0;
    col_rst_s   = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      flush_s = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d     = S_FETCH;
            issue_cnt_d = '0;
            busy_d      = 1'b1;
            col_rst_s   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          if (credit_s) begin
            issue_s    = 1'b1;
            rom_addr_d = issue_cnt_q;
            if (issue_cnt_q == LAST_ADDR) begin
              state_d = S_DRAIN;
            end else begin
              issue_cnt_d = issue_cnt_q + ADDR_W'(1);
            end
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (pop_s && last_q && (cnt_q == CNT_W'(1)) && (in_flight_s == '0)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          flush_s = 1'b1;
        end
      endcase
    end
  end

  // Tag pipe, FIFO pointers and the registered stream head.
  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    data_d   = data_q;
    col_d    = col_q;
    last_d   = last_q;
    remain_s = cnt_q - CNT_W'(pop_s);
    if (flush_s) begin
      tag_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
      col_d    = '0;
      last_d   = 1'b0;
    end else begin
      tag_d    = {tag_q[ROM_LAT-2:0], issue_s};
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      cnt_d    = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
      valid_d  = (cnt_d != '0);
      // An entry pushed into an otherwise empty FIFO bypasses straight to the head.
      if (remain_s != '0) begin
        data_d = mem_q[rd_ptr_d];
      end else if (push_s) begin
        data_d = rom_data_i;
      end else begin
        data_d = data_q;
      end
      if (col_rst_s) begin
        col_d = '0;
      end else if (pop_s && (col_q != LAST_COL)) begin
        col_d = col_q + COL_W'(1);
      end else begin
        col_d = col_q;
      end
      last_d = (col_d == LAST_COL);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      rom_addr_q  <= '0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      col_q       <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rom_addr_q  <= rom_addr_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      col_q       <= col_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // FIFO storage; ROM data lands here when its tag leaves the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s && !flush_s) begin
      mem_q[wr_ptr_q] <= rom_data_i;
    end
  end

  assign rom_addr_o       = rom_addr_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign char_o.char_valid = valid_q;
  assign char_o.char_data  = data_q;
  assign char_o.char_col   = col_q;
  assign char_o.char_last  = last_q;

endmodule
